// File: rtl/int_controller.sv
// int_controller
//   Vectored interrupt controller placed in front of the CPU interrupt inputs.
//   Each IRQ line is synchronised and then either edge-latched or level-mirrored
//   into PEND. The lowest-indexed pending and unmasked source wins. Its vector is
//   presented on int_num with int_in raised, and both are held until int_ack.
//
// Ports
//   clk        system clock, shared with the CPU
//   clr        asynchronous active-low reset
//   irq        raw asynchronous interrupt lines, active-high
//   int_in     interrupt request to the CPU (registered)
//   int_num    20-bit vector {VBASE, sel}, stable while int_in=1 (registered)
//   int_ack    CPU acknowledge; only the cycle it is sampled in REQ matters
//   cfg_we     register write strobe
//   cfg_addr   0=MASK 1=EDGE 2=PEND 3=VBASE
//   cfg_wdata  register write data
//   cfg_rdata  register read data, combinational from cfg_addr
//
// FSM states
//   state  | meaning
//   IDLE   | no request outstanding; latch winner and vector when any request is pending
//   REQ    | int_in=1, vector frozen; waiting for int_ack
//   HOLD   | one dead cycle so the CPU can drop int_ack and level sources can deassert

module int_controller #(
  parameter int N_SRC    = 8,
  parameter int SYNC_STG = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_SRC-1:0] irq,
  output logic             int_in,
  output logic [19:0]      int_num,
  input  logic             int_ack,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata
);

  localparam logic [1:0] A_MASK  = 2'd0;
  localparam logic [1:0] A_EDGE  = 2'd1;
  localparam logic [1:0] A_PEND  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Input path
  logic [SYNC_STG-1:0][N_SRC-1:0] sync_q;
  logic [N_SRC-1:0]               lvl_s;
  logic [N_SRC-1:0]               prev_q;
  logic [N_SRC-1:0]               rise;

  // Configuration / status
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] edge_q;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] pend_d;
  logic [14:0]      vbase_q;

  logic             wr_mask;
  logic             wr_edge;
  logic             wr_pend;
  logic             wr_vbase;
  logic [N_SRC-1:0] w1c;

  // Selection / FSM
  logic [N_SRC-1:0] req_vec;
  logic             req_any;
  logic [4:0]       sel_c;
  state_t           state_q;
  logic             int_in_q;
  logic [19:0]      int_num_q;
  logic [4:0]       sel_q;
  logic             ack_clr;

  logic             unused_wdata;
  assign unused_wdata = ^cfg_wdata;

  // ---------------------------------------------------------------------------
  // Synchroniser chain plus one edge-detect flop. sync_q[0] takes the raw line.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], irq};
      prev_q <= lvl_s;
    end
  end

  assign lvl_s = sync_q[SYNC_STG-1];
  // prev_q resets low, so a line already high at reset release yields one edge.
  assign rise  = lvl_s & ~prev_q;

  // ---------------------------------------------------------------------------
  // Register writes
  // ---------------------------------------------------------------------------
  assign wr_mask  = cfg_we && (cfg_addr == A_MASK);
  assign wr_edge  = cfg_we && (cfg_addr == A_EDGE);
  assign wr_pend  = cfg_we && (cfg_addr == A_PEND);
  assign wr_vbase = cfg_we && (cfg_addr == 2'd3);
  assign w1c      = wr_pend ? cfg_wdata[N_SRC-1:0] : '0;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mask_q  <= '0;
      edge_q  <= '0;
      vbase_q <= '0;
    end else begin
      if (wr_mask)  mask_q  <= cfg_wdata[N_SRC-1:0];
      if (wr_edge)  edge_q  <= cfg_wdata[N_SRC-1:0];
      if (wr_vbase) vbase_q <= cfg_wdata[19:5];
    end
  end

  // ---------------------------------------------------------------------------
  // PEND: edge sources set on rise and clear on W1C or their own ack, with the
  // set taking priority. Level sources simply track the synchronised line.
  // ---------------------------------------------------------------------------
  assign ack_clr = (state_q == S_REQ) && int_ack;

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (edge_q[i]) begin
        if (rise[i]) begin
          pend_d[i] = 1'b1;
        end else if (w1c[i] || (ack_clr && (sel_q == 5'(i)))) begin
          pend_d[i] = 1'b0;
        end
      end else begin
        pend_d[i] = lvl_s[i];
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      A_MASK:  cfg_rdata[N_SRC-1:0] = mask_q;
      A_EDGE:  cfg_rdata[N_SRC-1:0] = edge_q;
      A_PEND:  cfg_rdata[N_SRC-1:0] = pend_q;
      default: cfg_rdata[19:5]      = vbase_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Priority pick: scanning downward lets the lowest set index win.
  // ---------------------------------------------------------------------------
  assign req_vec = pend_q & mask_q;
  assign req_any = |req_vec;

  always_comb begin
    sel_c = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_vec[i]) sel_c = 5'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM. The vector uses current register values, so a cfg write in
  // the entry cycle is not reflected until the next request.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      int_in_q  <= 1'b0;
      int_num_q <= '0;
      sel_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            state_q   <= S_REQ;
            int_in_q  <= 1'b1;
            sel_q     <= sel_c;
            int_num_q <= {vbase_q, sel_c};
          end
        end
        S_REQ: begin
          if (int_ack) begin
            state_q  <= S_HOLD;
            int_in_q <= 1'b0;
          end
        end
        S_HOLD: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          int_in_q <= 1'b0;
        end
      endcase
    end
  end

  assign int_in  = int_in_q;
  assign int_num = int_num_q;

endmodule

// File: tb/tb_int_controller.sv
module tb_int_controller;

  localparam int N    = 8;
  localparam int SYNC = 2;

  logic          clk;
  logic          clr;
  logic [N-1:0]  irq;
  logic          int_in;
  logic [19:0]   int_num;
  logic          int_ack;
  logic          cfg_we;
  logic [1:0]    cfg_addr;
  logic [31:0]   cfg_wdata;
  logic [31:0]   cfg_rdata;

  int total;
  int bad;
  logic [19:0] exp_q[$];

  int_controller #(.N_SRC(N), .SYNC_STG(SYNC)) dut (
    .clk       (clk),
    .clr       (clr),
    .irq       (irq),
    .int_in    (int_in),
    .int_num   (int_num),
    .int_ack   (int_ack),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    cfg_addr = a;
    #1;
    chk(tag, cfg_rdata, exp);
  endtask

  task automatic pulse(input logic [N-1:0] bits);
    irq = irq | bits;
    @(negedge clk);
    irq = irq & ~bits;
  endtask

  task automatic ack;
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
  endtask

  // Wait (bounded) for int_in, then check int_num against the scoreboard head.
  task automatic wait_req(input string tag, input int max_cyc, output int cyc);
    logic [19:0] e;
    cyc = 0;
    while (int_in !== 1'b1 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    if (int_in === 1'b1) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_vec"}, 32'(int_num), 32'(e));
      end else begin
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      end
    end else begin
      chk({tag, "_timeout"}, 32'(int_in), 32'd1);
    end
  endtask

  task automatic no_req(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (int_in !== 1'b0) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int cyc;
    total     = 0;
    bad       = 0;
    clr       = 1'b0;
    irq       = '0;
    int_ack   = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = 2'd0;
    cfg_wdata = '0;

    // Reset state
    step(3);
    chk("rst_int_in", 32'(int_in), 32'd0);
    chk("rst_int_num", 32'(int_num), 32'd0);
    rd_chk("rst_mask", 2'd0, 32'd0);
    rd_chk("rst_edge", 2'd1, 32'd0);
    rd_chk("rst_pend", 2'd2, 32'd0);
    rd_chk("rst_vbase", 2'd3, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    step(1);

    // 1: single edge source, latency and vector
    cfg_wr(2'd0, 32'h01);
    cfg_wr(2'd1, 32'h01);
    cfg_wr(2'd3, 32'h800);
    rd_chk("t1_vbase_rd", 2'd3, 32'h800);
    exp_q.push_back(20'h00800);
    pulse(8'h01);
    wait_req("t1", 10, cyc);
    chk("t1_latency", 32'(cyc + 1), 32'(SYNC + 2));
    rd_chk("t1_pend_set", 2'd2, 32'h01);
    ack;
    chk("t1_hold_low", 32'(int_in), 32'd0);
    rd_chk("t1_pend_clr", 2'd2, 32'h00);
    no_req("t1_stay_low", 5);

    // 2: simultaneous edges, priority order
    cfg_wr(2'd0, 32'hFF);
    cfg_wr(2'd1, 32'hFF);
    exp_q.push_back(20'h00802);
    exp_q.push_back(20'h00805);
    pulse(8'h24);
    wait_req("t2a", 10, cyc);
    rd_chk("t2_pend_both", 2'd2, 32'h24);
    ack;
    wait_req("t2b", 6, cyc);
    chk("t2_rereq_gap", 32'(cyc), 32'd2);
    ack;
    rd_chk("t2_pend_clr", 2'd2, 32'h00);
    no_req("t2_stay_low", 4);

    // 3: level source 3
    cfg_wr(2'd1, 32'hF7);
    irq[3] = 1'b1;
    exp_q.push_back(20'h00803);
    wait_req("t3a", 10, cyc);
    ack;
    rd_chk("t3_pend_level_kept", 2'd2, 32'h08);
    exp_q.push_back(20'h00803);
    wait_req("t3b", 6, cyc);
    chk("t3_rereq_gap", 32'(cyc), 32'd2);
    // Source deasserts well before the ack so PEND is low by the end of HOLD.
    irq[3] = 1'b0;
    step(SYNC + 2);
    chk("t3_req_held", 32'(int_in), 32'd1);
    rd_chk("t3_pend_dropped", 2'd2, 32'h00);
    ack;
    no_req("t3_no_rereq", 6);

    // 4: mask / W1C during REQ do not withdraw the request
    cfg_wr(2'd1, 32'hFF);
    exp_q.push_back(20'h00801);
    pulse(8'h02);
    wait_req("t4", 10, cyc);
    cfg_wr(2'd0, 32'h00);
    cfg_wr(2'd2, 32'h02);
    chk("t4_int_in_held", 32'(int_in), 32'd1);
    chk("t4_int_num_held", 32'(int_num), 32'h00801);
    rd_chk("t4_pend_w1c", 2'd2, 32'h00);
    ack;
    no_req("t4_no_req", 6);

    // 6: new edge coincides with the ack-clear of the same source
    cfg_wr(2'd0, 32'hFF);
    exp_q.push_back(20'h00804);
    pulse(8'h10);
    wait_req("t6a", 10, cyc);
    step(4);
    exp_q.push_back(20'h00804);
    pulse(8'h10);
    step(SYNC - 1);
    ack;
    chk("t6_hold_low", 32'(int_in), 32'd0);
    rd_chk("t6_pend_set_wins", 2'd2, 32'h10);
    wait_req("t6b", 6, cyc);
    chk("t6_rereq_gap", 32'(cyc), 32'd2);
    ack;
    rd_chk("t6_pend_clr", 2'd2, 32'h00);

    // 5: asynchronous reset in the middle of REQ
    exp_q.push_back(20'h00806);
    pulse(8'h40);
    wait_req("t5a", 10, cyc);
    #2;
    clr = 1'b0;
    #1;
    chk("t5_int_in_async", 32'(int_in), 32'd0);
    chk("t5_int_num_async", 32'(int_num), 32'd0);
    for (int a = 0; a < 4; a++) begin
      cfg_addr = 2'(a);
      #1;
      chk("t5_rdata_zero", cfg_rdata, 32'd0);
    end
    irq[6] = 1'b1;
    step(2);
    clr = 1'b1;
    no_req("t5_masked_after_rst", 8);
    rd_chk("t5_pend_level", 2'd2, 32'h40);
    cfg_wr(2'd1, 32'hFF);
    exp_q.push_back(20'h00006);
    cfg_wr(2'd0, 32'h40);
    wait_req("t5b", 10, cyc);
    ack;
    rd_chk("t5_pend_clr", 2'd2, 32'h00);
    no_req("t5_single_edge", 6);
    irq = '0;

    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
